gray_counter_ctrl: RTL and testbench

GRAY_COUNTER_CTRL -- requirements
Module: gray_counter_ctrl

---
 rtl/gray_counter_ctrl.sv | 150 +++++++++++++++
 tb/tb_gray_counter_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_ctrl.sv
// Run/pause/step controller for a 4-bit up/down counter: debounced pushbuttons
// drive a small FSM, a prescaler paces RUN ticks, and pos shadows the counter.

module gray_counter_debounce #(
  parameter int DEBOUNCE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // level flips on the DEBOUNCE-th consecutive differing sample; a 0->1 flip
  // is registered as the press pulse in the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        level <= sync[1];
        press <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module gray_counter_ctrl #(
  parameter int LIMIT    = 100000000,
  parameter int DEBOUNCE = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_step,
  input  logic       sw_dir,
  output logic       tick,
  output logic       up_down,
  output logic [1:0] state,
  output logic       wrap,
  output logic [3:0] pos
);
  localparam int NUM_BTN = 3;
  localparam int PW      = $clog2(LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    STEP  = 2'b11
  } state_t;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_press;
  logic               p_stop, p_start, p_step;
  logic [1:0]         dir_sync;
  logic [PW-1:0]      pcnt;
  state_t             st;

  assign btn_raw = {btn_step, btn_start, btn_stop};
  assign p_stop  = btn_press[0];
  assign p_start = btn_press[1];
  assign p_step  = btn_press[2];
  assign state   = st;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    gray_counter_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[g]),
      .press (btn_press[g])
    );
  end

  // stop outranks start outranks step; a stop in a tick-scheduled RUN cycle
  // still lets that tick out because the prescaler runs for the whole cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= IDLE;
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (st == RUN) begin
        if (pcnt == PW'(LIMIT - 1)) begin
          pcnt <= '0;
          tick <= 1'b1;
        end else begin
          pcnt <= pcnt + 1'b1;
        end
      end
      if (st == STEP) tick <= 1'b1;
      unique case (st)
        IDLE: begin
          if (p_stop)       st <= IDLE;
          else if (p_start) st <= RUN;
          else if (p_step)  st <= STEP;
        end
        RUN: begin
          if (p_stop) st <= PAUSE;
        end
        PAUSE: begin
          if (p_stop) begin
            st   <= IDLE;
            pcnt <= '0;
          end else if (p_start) begin
            st <= RUN;
          end else if (p_step) begin
            st <= STEP;
          end
        end
        STEP: st <= PAUSE;
      endcase
    end
  end

  // direction is frozen while tick is high so the step it governs is the one
  // the datapath sees
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_sync <= '0;
      up_down  <= 1'b1;
      pos      <= '0;
      wrap     <= 1'b0;
    end else begin
      dir_sync <= {dir_sync[0], sw_dir};
      if (!tick) up_down <= dir_sync[1];
      wrap <= 1'b0;
      if (tick) begin
        pos  <= up_down ? pos + 4'd1 : pos - 4'd1;
        wrap <= up_down ? (pos == 4'hF) : (pos == 4'h0);
      end
    end
  end
endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Scoreboard bench: expected pos/wrap per tick are queued as stimulus is
// driven and popped by a monitor when the DUT's pos update lands.
`timescale 1ns/1ps
module tb_gray_counter_ctrl;
  localparam int LIMIT    = 4;
  localparam int DEBOUNCE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0, btn_stop = 1'b0, btn_step = 1'b0, sw_dir = 1'b1;
  logic       tick, up_down, wrap;
  logic [1:0] state;
  logic [3:0] pos;

  gray_counter_ctrl #(.LIMIT(LIMIT), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .btn_step  (btn_step),
    .sw_dir    (sw_dir),
    .tick      (tick),
    .up_down   (up_down),
    .state     (state),
    .wrap      (wrap),
    .pos       (pos)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pos;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mpos  = 0;
  logic tick_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_ticks(input int n, input bit up);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.wrap = up ? (mpos == 15) : (mpos == 0);
      mpos   = up ? (mpos + 1) % 16 : (mpos + 15) % 16;
      e.pos  = 4'(mpos);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (state === s) break;
    end
    chk(tag, state, s);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (tick === 1'b1) break;
    end
  endtask

  // pos/wrap are compared in the cycle after each tick
  always @(negedge clk) begin
    if (tick_seen) begin
      if (exp_q.size() == 0) chk("extra_tick", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("tick_pos", pos, mon_e.pos);
        chk("tick_wrap", wrap, mon_e.wrap);
      end
    end else if (wrap === 1'b1) begin
      chk("wrap_stray", wrap, 0);
    end
    tick_seen <= (tick === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    btn_start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_tick", tick, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_pos", pos, 0);
    chk("rst_updown", up_down, 1);

    // start held through reset release
    push_ticks(3, 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_rst_idle", state, 0);
    @(negedge clk);
    chk("start_latency", state, 1);
    wait_tick(n); chk("gap_first", n, LIMIT);
    wait_tick(n); chk("gap_2", n, LIMIT);
    wait_tick(n); chk("gap_3", n, LIMIT);

    // bouncing stop: 1,0,1,0 then 5 high
    push_ticks(2, 1);
    btn_stop = 1'b1; @(negedge clk);
    btn_stop = 1'b0; @(negedge clk);
    btn_stop = 1'b1; @(negedge clk);
    btn_stop = 1'b0; @(negedge clk);
    btn_stop = 1'b1;
    repeat (5) @(negedge clk);
    chk("bounce_run", state, 1);
    btn_stop = 1'b0;
    @(negedge clk);
    chk("bounce_pause", state, 2);
    repeat (12) @(negedge clk);
    chk("pause_hold", state, 2);
    chk("pos_pause", pos, 5);
    chk("q_empty_stop", exp_q.size(), 0);
    btn_start = 1'b0;
    repeat (8) @(negedge clk);

    // three step presses, the last one held long
    for (int k = 0; k < 3; k++) begin
      push_ticks(1, 1);
      btn_step = 1'b1;
      wait_state(2'b11, "step_enter");
      chk("step_no_tick", tick, 0);
      if (k < 2) btn_step = 1'b0;
      @(negedge clk);
      chk("step_exit", state, 2);
      chk("step_tick", tick, 1);
      @(negedge clk);
      chk("step_tick_once", tick, 0);
      repeat (k == 2 ? 14 : 8) @(negedge clk);
      btn_step = 1'b0;
    end
    repeat (8) @(negedge clk);
    chk("pos_steps", pos, 8);
    chk("steps_pause", state, 2);

    // start and stop accepted together in PAUSE
    btn_start = 1'b1; btn_stop = 1'b1;
    repeat (5) @(negedge clk);
    chk("both_pre", state, 2);
    @(negedge clk);
    chk("both_idle", state, 0);
    btn_start = 1'b0; btn_stop = 1'b0;
    repeat (10) @(negedge clk);
    chk("both_stay_idle", state, 0);

    // count down from 8 through 0 to 15
    sw_dir = 1'b0;
    repeat (4) @(negedge clk);
    chk("dir_down", up_down, 0);
    push_ticks(9, 0);
    btn_start = 1'b1;
    wait_state(2'b01, "run_down");
    btn_start = 1'b0;
    wait_tick(n); chk("gap_after_idle", n, LIMIT);
    for (int k = 0; k < 7; k++) begin
      wait_tick(n); chk("gap_down", n, LIMIT);
    end
    btn_stop = 1'b1;
    repeat (5) @(negedge clk);
    chk("down_pos", pos, 15);
    chk("down_wrap", wrap, 1);
    chk("down_run", state, 1);
    @(negedge clk);
    chk("wrap_once", wrap, 0);
    chk("down_pause", state, 2);
    btn_stop = 1'b0;
    repeat (8) @(negedge clk);

    // resume upward from 15 with the held prescale value
    sw_dir = 1'b1;
    repeat (4) @(negedge clk);
    chk("dir_up", up_down, 1);
    push_ticks(1, 1);
    btn_start = 1'b1;
    wait_state(2'b01, "resume");
    btn_start = 1'b0;
    wait_tick(n); chk("gap_resume", n, 2);

    // stop lands in the cycle a tick is scheduled
    push_ticks(2, 1);
    repeat (2) @(negedge clk);
    btn_stop = 1'b1;
    repeat (5) @(negedge clk);
    chk("blk_run", state, 1);
    @(negedge clk);
    chk("blk_pause", state, 2);
    chk("blk_tick", tick, 1);
    btn_stop = 1'b0;
    repeat (12) @(negedge clk);
    chk("blk_q_empty", exp_q.size(), 0);
    chk("blk_pos", pos, 2);

    // reset mid-RUN at pos 7, pcnt 2
    push_ticks(5, 1);
    btn_start = 1'b1;
    wait_state(2'b01, "run_to_7");
    btn_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_tick(n); chk("gap_to_7", n, LIMIT);
    end
    repeat (2) @(negedge clk);
    chk("pre_rst_pos", pos, 7);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_pos", pos, 0);
    chk("mid_rst_tick", tick, 0);
    chk("mid_rst_wrap", wrap, 0);
    chk("mid_rst_updown", up_down, 1);
    rst = 1'b0;
    mpos = 0;
    repeat (10) @(negedge clk);
    chk("post_rst_idle", state, 0);

    // prescaler restarts from zero after reset
    push_ticks(1, 1);
    btn_start = 1'b1;
    wait_state(2'b01, "post_rst_run");
    btn_start = 1'b0;
    wait_tick(n); chk("gap_post_rst", n, LIMIT);
    repeat (2) @(negedge clk);
    chk("final_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
